// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Holds the PS/2 clock low, issues request-to-send, then shifts the start bit,
// eight data bits (LSB first), odd parity and stop on device-generated falling
// clock edges, and samples the device ACK on the eleventh falling edge.
// rx_hold keeps the neighbouring receiver quiet for the whole host frame.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_s,
    input  logic       ps2_data_s,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_hold,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Odd parity bit: makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t           state_r;
    logic [7:0]       shift_r;
    logic             parity_r;
    logic [3:0]       bit_cnt_r;
    logic [INH_W-1:0] inh_cnt_r;
    logic [WD_W-1:0]  wdog_cnt_r;
    logic             prev_clk_r;
    logic             clk_oe_r;
    logic             data_oe_r;
    logic             tx_ready_r;
    logic             rx_hold_r;
    logic             done_r;
    logic             ack_ok_r;
    logic             error_r;

    logic             fall_s;
    logic [3:0]       bit_next_s;
    logic             wdog_expire_s;

    assign fall_s        = prev_clk_r & ~ps2_clk_s;
    assign bit_next_s    = bit_cnt_r + 4'd1;
    assign wdog_expire_s = (wdog_cnt_r == WD_LAST);

    assign tx_ready    = tx_ready_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign rx_hold     = rx_hold_r;
    assign done        = done_r;
    assign ack_ok      = ack_ok_r;
    assign error       = error_r;

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            parity_r   <= 1'b0;
            bit_cnt_r  <= 4'd0;
            inh_cnt_r  <= '0;
            wdog_cnt_r <= '0;
            prev_clk_r <= 1'b1;
            clk_oe_r   <= 1'b0;
            data_oe_r  <= 1'b0;
            tx_ready_r <= 1'b1;
            rx_hold_r  <= 1'b0;
            done_r     <= 1'b0;
            ack_ok_r   <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            prev_clk_r <= ps2_clk_s;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // tx_ready_r is high throughout IDLE, so tx_valid alone means accept.
                    if (tx_valid) begin
                        shift_r    <= tx_data;
                        parity_r   <= odd_parity(tx_data);
                        bit_cnt_r  <= 4'd0;
                        inh_cnt_r  <= '0;
                        ack_ok_r   <= 1'b0;
                        clk_oe_r   <= 1'b1;
                        data_oe_r  <= 1'b0;
                        tx_ready_r <= 1'b0;
                        rx_hold_r  <= 1'b1;
                        state_r    <= ST_INHIBIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INHIBIT: begin
                    if (inh_cnt_r == INH_LAST) begin
                        data_oe_r <= 1'b1;
                        state_r   <= ST_REQ;
                    end else begin
                        inh_cnt_r <= inh_cnt_r + INH_ONE;
                    end
                end
                ST_REQ: begin
                    // Release the clock with data still low: request-to-send.
                    clk_oe_r   <= 1'b0;
                    wdog_cnt_r <= '0;
                    state_r    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (wdog_expire_s) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        ack_ok_r   <= 1'b0;
                        error_r    <= 1'b1;
                        tx_ready_r <= 1'b1;
                        rx_hold_r  <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + WD_ONE;
                        if (fall_s) begin
                            bit_cnt_r <= bit_next_s;
                            if (bit_next_s <= 4'd8) begin
                                data_oe_r <= ~shift_r[0];
                                shift_r   <= {1'b0, shift_r[7:1]};
                            end else if (bit_next_s == 4'd9) begin
                                data_oe_r <= ~parity_r;
                            end else if (bit_next_s == 4'd10) begin
                                data_oe_r <= 1'b0;
                            end else begin
                                ack_ok_r  <= ~ps2_data_s;
                                data_oe_r <= 1'b0;
                                state_r   <= ST_WAIT_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (wdog_expire_s) begin
                        clk_oe_r   <= 1'b0;
                        data_oe_r  <= 1'b0;
                        ack_ok_r   <= 1'b0;
                        error_r    <= 1'b1;
                        tx_ready_r <= 1'b1;
                        rx_hold_r  <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + WD_ONE;
                        if (ps2_clk_s && ps2_data_s) begin
                            done_r     <= 1'b1;
                            tx_ready_r <= 1'b1;
                            rx_hold_r  <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT_IDLE;
                        end
                    end
                end
                default: begin
                    clk_oe_r   <= 1'b0;
                    data_oe_r  <= 1'b0;
                    tx_ready_r <= 1'b1;
                    rx_hold_r  <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device drives the open-drain
// bus, reads back the host frame bit by bit and answers with ACK or NACK.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 3000;

    logic       sys_clk  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_hold, done, ack_ok, error;
    logic       ps2_clk_s, ps2_data_s;

    // Wired-AND open-drain bus between host and device.
    assign ps2_clk_s  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_s = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_s(ps2_clk_s), .ps2_data_s(ps2_data_s),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .rx_hold(rx_hold),
        .done(done), .ack_ok(ack_ok), .error(error)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Observation counters maintained by the monitors below.
    int   inh_cur = 0, inh_len = 0, req_cur = 0, req_len = 0, rel_cnt = 0, err_rel = 0;
    int   done_cnt = 0, err_cnt = 0, accept_cnt = 0, acc_at_done = 0;
    logic ack_at_done = 1'b0, ready_after = 1'b0, done_prev = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       st, par, sp;
        bit         rts_ok;
        int         done_inc, err_inc;
    } obs_t;

    // Count handshakes exactly as the DUT sees them on the active edge.
    always @(posedge sys_clk) begin
        if (!reset && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
    end

    // Measure inhibit/RTS lengths, watchdog time, and done/error pulses.
    always @(negedge sys_clk) begin
        if (ps2_clk_oe) inh_cur <= inh_cur + 1;
        else if (inh_cur != 0) begin inh_len <= inh_cur; inh_cur <= 0; end
        if (ps2_clk_oe && ps2_data_oe) req_cur <= req_cur + 1;
        else if (req_cur != 0) begin req_len <= req_cur; req_cur <= 0; end
        if (ps2_clk_oe) rel_cnt <= 0;
        else if (rx_hold) rel_cnt <= rel_cnt + 1;
        if (error) begin err_cnt <= err_cnt + 1; err_rel <= rel_cnt; end
        if (done) begin done_cnt <= done_cnt + 1; ack_at_done <= ack_ok; acc_at_done <= accept_cnt; end
        if (done_prev) ready_after <= tx_ready;
        done_prev <= done;
    end

    // Reference parity: 1 when the byte holds an even number of ones.
    function automatic logic model_parity(input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(b[i]);
        return (n % 2 == 0);
    endfunction

    task automatic start_tx(input logic [7:0] b);
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge sys_clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
    endtask

    // Device model: wait for RTS, clock n_edges falls with the given half period,
    // sample the line on each rising edge, drive ACK low before fall 11 if asked.
    task automatic run_device(input bit ack, input int n_edges, input int half,
                              output logic [7:0] d, output logic st, output logic par,
                              output logic sp, output bit ok);
        int i;
        ok = 1'b0; d = 8'h00; st = 1'bx; par = 1'bx; sp = 1'bx;
        for (i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (!ps2_clk_oe && ps2_data_oe) break;
        end
        if (i == 200) return;
        ok = 1'b1;
        repeat (half) @(negedge sys_clk);
        st = ps2_data_s;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            repeat (half) @(negedge sys_clk);
            if (k <= 8) d[k-1] = ps2_data_s;
            else if (k == 9) par = ps2_data_s;
            else if (k == 10) sp = ps2_data_s;
            dev_clk = 1'b1;
            repeat (half) @(negedge sys_clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit ack, input int half, output obs_t o);
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(b);
        tx_data = ~b;
        run_device(ack, 11, half, o.d, o.st, o.par, o.sp, o.rts_ok);
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        o.done_inc = done_cnt - d0;
        o.err_inc  = err_cnt - e0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        total++; if (tx_ready !== 1'b1)    begin bad++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
        total++; if (ps2_clk_oe !== 1'b0)  begin bad++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
        total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
        total++; if (rx_hold !== 1'b0)     begin bad++; $display("FAIL rst_rx_hold: got %b want 0", rx_hold); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (ack_ok !== 1'b0)      begin bad++; $display("FAIL rst_ack_ok: got %b want 0", ack_ok); end
        total++; if (error !== 1'b0)       begin bad++; $display("FAIL rst_error: got %b want 0", error); end
        reset = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_directed;
        logic [7:0] bytes [3] = '{8'hED, 8'h01, 8'hFF};
        bit         acks  [3] = '{1'b1, 1'b1, 1'b0};
        obs_t o;
        for (int t = 0; t < 3; t++) begin
            do_frame(bytes[t], acks[t], 6, o);
            total++; if (!o.rts_ok) begin bad++; $display("FAIL dir_rts[%h]: got no RTS want RTS", bytes[t]); end
            total++; if (inh_len != INH + 1) begin bad++; $display("FAIL dir_inhibit_len[%h]: got %0d want %0d", bytes[t], inh_len, INH + 1); end
            total++; if (req_len != 1) begin bad++; $display("FAIL dir_req_len[%h]: got %0d want 1", bytes[t], req_len); end
            total++; if (o.st !== 1'b0) begin bad++; $display("FAIL dir_start[%h]: got %b want 0", bytes[t], o.st); end
            total++; if (o.d !== bytes[t]) begin bad++; $display("FAIL dir_data[%h]: got %h want %h", bytes[t], o.d, bytes[t]); end
            total++; if (o.par !== model_parity(bytes[t])) begin bad++; $display("FAIL dir_parity[%h]: got %b want %b", bytes[t], o.par, model_parity(bytes[t])); end
            total++; if (o.sp !== 1'b1) begin bad++; $display("FAIL dir_stop[%h]: got %b want 1", bytes[t], o.sp); end
            total++; if (o.done_inc != 1) begin bad++; $display("FAIL dir_done[%h]: got %0d pulses want 1", bytes[t], o.done_inc); end
            total++; if (ack_at_done !== acks[t]) begin bad++; $display("FAIL dir_ack[%h]: got %b want %b", bytes[t], ack_at_done, acks[t]); end
            total++; if (o.err_inc != 0) begin bad++; $display("FAIL dir_error[%h]: got %0d pulses want 0", bytes[t], o.err_inc); end
            total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL dir_ready_after_done[%h]: got %b want 1", bytes[t], ready_after); end
        end
    endtask

    task automatic test_random;
        obs_t o;
        logic [7:0] b;
        bit ack;
        for (int t = 0; t < 6; t++) begin
            b   = 8'($urandom_range(0, 255));
            ack = 1'($urandom_range(0, 1));
            do_frame(b, ack, int'($urandom_range(3, 8)), o);
            total++; if (o.d !== b) begin bad++; $display("FAIL rnd_data: got %h want %h", o.d, b); end
            total++; if (o.par !== model_parity(b)) begin bad++; $display("FAIL rnd_parity[%h]: got %b want %b", b, o.par, model_parity(b)); end
            total++; if (o.done_inc != 1 || ack_at_done !== ack) begin bad++; $display("FAIL rnd_done_ack[%h]: got done=%0d ack=%b want done=1 ack=%b", b, o.done_inc, ack_at_done, ack); end
        end
    endtask

    task automatic test_timeout;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h00);
        for (int i = 0; i < TO + 300 && err_cnt == e0; i++) @(negedge sys_clk);
        total++; if (err_cnt != e0 + 1) begin bad++; $display("FAIL to_error: got %0d pulses want 1", err_cnt - e0); end
        total++; if (err_rel < TO - 1 || err_rel > TO + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", err_rel, TO); end
        total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL to_lines: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
        repeat (20) @(negedge sys_clk);
        total++; if (done_cnt != d0) begin bad++; $display("FAIL to_no_done: got %0d pulses want 0", done_cnt - d0); end
        total++; if (ack_ok !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL to_idle: got ack_ok=%b tx_ready=%b want 0 1", ack_ok, tx_ready); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        logic st, par, sp;
        bit ok;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hAA);
        run_device(1'b1, 5, 5, d, st, par, sp, ok);
        total++; if (!ok || rx_hold !== 1'b1) begin bad++; $display("FAIL mid_in_frame: got rts=%b rx_hold=%b want 1 1", ok, rx_hold); end
        reset = 1'b1;
        @(negedge sys_clk);
        total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin bad++; $display("FAIL mid_lines: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
        total++; if (rx_hold !== 1'b0 || tx_ready !== 1'b1) begin bad++; $display("FAIL mid_flags: got rx_hold=%b tx_ready=%b want 0 1", rx_hold, tx_ready); end
        reset = 1'b0;
        repeat (20) @(negedge sys_clk);
        total++; if (done_cnt != d0 || err_cnt != e0) begin bad++; $display("FAIL mid_no_pulse: got done=%0d error=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic st, par, sp;
        bit ok;
        int a0, d0;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge sys_clk);
        a0 = accept_cnt; d0 = done_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        run_device(1'b1, 11, 5, d, st, par, sp, ok);
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        total++; if (d !== 8'h55) begin bad++; $display("FAIL b2b_data1: got %h want 55", d); end
        total++; if (acc_at_done != a0 + 1) begin bad++; $display("FAIL b2b_single: got %0d accepts want 1", acc_at_done - a0); end
        total++; if (accept_cnt != a0 + 2 || ps2_clk_oe !== 1'b1) begin bad++; $display("FAIL b2b_second_start: got accepts=%0d clk_oe=%b want 2 1", accept_cnt - a0, ps2_clk_oe); end
        tx_valid = 1'b0;
        d0 = done_cnt;
        run_device(1'b1, 11, 5, d, st, par, sp, ok);
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        total++; if (d !== 8'h55 || done_cnt != d0 + 1) begin bad++; $display("FAIL b2b_frame2: got data=%h done=%0d want 55 1", d, done_cnt - d0); end
        total++; if (accept_cnt != a0 + 2) begin bad++; $display("FAIL b2b_no_third: got %0d accepts want 2", accept_cnt - a0); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
